pwm_duty_scheduler: RTL

PWM_DUTY_SCHEDULER -- requirements
Module: pwm_duty_scheduler

---
 rtl/pwm_sched_pkg.sv | 15 +
 rtl/rr_arbiter.sv | 37 +++
 rtl/pwm_duty_scheduler.sv | 118 +++++++++++
 3 files changed

// File: rtl/pwm_sched_pkg.sv
// Shared types and defaults for the PWM duty scheduler.
// Latency: n/a (declarations only).
// Backpressure: n/a.
package pwm_sched_pkg;

    localparam int DEF_NREQ  = 4;
    localparam int DEF_WIDTH = 8;

    // IDLE: nothing staged. STAGED: one accepted duty value waits for the period wrap.
    typedef enum logic {
        IDLE   = 1'b0,
        STAGED = 1'b1
    } sched_state_t;

endpackage

// File: rtl/rr_arbiter.sv
// Round-robin one-hot grant: first set request at or after ptr, wrapping modulo NREQ.
// Latency: purely combinational, zero cycles.
// Backpressure: none; the caller masks req when it cannot accept.
//
// Ports:
//   req   - request vector, bit i = requester i wants service
//   ptr   - highest-priority index for this search
//   grant - one-hot grant, all zeros when req is empty
module rr_arbiter
    import pwm_sched_pkg::*;
#(
    parameter int NREQ = DEF_NREQ
) (
    input  logic [NREQ-1:0]         req,
    input  logic [$clog2(NREQ)-1:0] ptr,
    output logic [NREQ-1:0]         grant
);

    logic found;

    // Walk distances k = 0..NREQ-1 away from ptr; the requester at distance k
    // is index j where ptr + k == j or ptr + k == j + NREQ (the wrapped case).
    always_comb begin
        grant = '0;
        found = 1'b0;
        for (int k = 0; k < NREQ; k++) begin
            for (int j = 0; j < NREQ; j++) begin
                if (!found && req[j] &&
                    ((int'(ptr) + k == j) || (int'(ptr) + k == j + NREQ))) begin
                    grant[j] = 1'b1;
                    found    = 1'b1;
                end
            end
        end
    end

endmodule

// File: rtl/pwm_duty_scheduler.sv
// PWM generator whose duty is supplied by NREQ round-robin requesters and committed only at period wrap.
// Latency: an accepted duty reaches duty_out at the next counter wrap (2^WIDTH cycles if accepted at the wrap itself).
// Backpressure: req_ready is held low while a value is staged; one transfer per period at most.
//
// Ports:
//   clk, rst          - clock; asynchronous active-low reset
//   req_valid/_ready  - per-requester handshake, req_ready is one-hot
//   req_duty          - packed duties, requester i at [i*WIDTH +: WIDTH]
//   duty_out, owner   - committed duty and the requester that supplied it
//   pwm_out           - high while counter < duty_out
//   period_start      - high while counter == 0
//   busy              - a value is staged but not yet committed
module pwm_duty_scheduler
    import pwm_sched_pkg::*;
#(
    parameter int NREQ  = DEF_NREQ,
    parameter int WIDTH = DEF_WIDTH
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic [NREQ-1:0]         req_valid,
    input  logic [NREQ*WIDTH-1:0]   req_duty,
    output logic [NREQ-1:0]         req_ready,
    output logic [WIDTH-1:0]        duty_out,
    output logic                    pwm_out,
    output logic                    period_start,
    output logic [$clog2(NREQ)-1:0] owner,
    output logic                    busy
);

    localparam int               IDW     = $clog2(NREQ);
    localparam logic [WIDTH-1:0] CNT_MAX = '1;
    localparam logic [IDW-1:0]   ID_LAST = IDW'(NREQ - 1);

    sched_state_t     state;
    sched_state_t     state_nxt;
    logic [WIDTH-1:0] counter;
    logic [WIDTH-1:0] staged;
    logic [IDW-1:0]   staged_id;
    logic [IDW-1:0]   ptr;
    logic [NREQ-1:0]  arb_req;
    logic [NREQ-1:0]  grant;
    logic [IDW-1:0]   grant_id;
    logic [WIDTH-1:0] grant_duty;
    logic             xfer;
    logic             wrap;

    assign wrap    = (counter == CNT_MAX);
    assign arb_req = (state == IDLE) ? req_valid : '0;

    rr_arbiter #(
        .NREQ (NREQ)
    ) u_arb (
        .req   (arb_req),
        .ptr   (ptr),
        .grant (grant)
    );

    // Outputs that would otherwise follow counter==0 during reset are gated by rst.
    assign req_ready    = rst ? grant : '0;
    assign xfer         = |(req_valid & req_ready);
    assign pwm_out      = rst & (counter < duty_out);
    assign period_start = rst & (counter == '0);
    assign busy         = (state == STAGED);

    // Encode the one-hot grant and pick the matching duty slice.
    always_comb begin
        grant_id   = '0;
        grant_duty = '0;
        for (int j = 0; j < NREQ; j++) begin
            if (grant[j]) begin
                grant_id   = IDW'(j);
                grant_duty = req_duty[j*WIDTH +: WIDTH];
            end
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // An accept on the wrap cycle lands in STAGED and therefore waits a full
    // period, since the commit test only happens while already STAGED.
    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:   if (xfer) state_nxt = STAGED;
            STAGED: if (wrap) state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            counter   <= '0;
            staged    <= '0;
            staged_id <= '0;
            ptr       <= '0;
            duty_out  <= '0;
            owner     <= '0;
        end else begin
            counter <= counter + WIDTH'(1);
            if (state == IDLE && xfer) begin
                staged    <= grant_duty;
                staged_id <= grant_id;
                ptr       <= (grant_id == ID_LAST) ? '0 : grant_id + IDW'(1);
            end
            if (state == STAGED && wrap) begin
                duty_out <= staged;
                owner    <= staged_id;
            end
        end
    end

endmodule
